// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - three-stage pipelined Barrett reducer (din mod Q) with valid/ready and sideband tag
module barrett_reduce_pipe #(
    parameter int Q     = 277,
    parameter int QW    = $clog2(Q),
    parameter int K     = QW,
    parameter int DIN_W = 2 * QW,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    dout,
    output logic [TAG_W-1:0] out_tag
);

    // Barrett constant floor(2^(2K)/Q); Q >= 2^(QW-1) bounds it below 2^(2K-QW+1)
    localparam longint unsigned MU_L = (64'd1 << (2 * K)) / 64'(Q);
    localparam int MU_W = 2 * K - QW + 1;
    localparam logic [MU_W-1:0] MU = MU_W'(MU_L);

    // Quotient-estimate widths: q = din >> K, p = q * MU, t = p >> K
    localparam int QQ_W = DIN_W - K;
    localparam int P_W  = QQ_W + MU_W;
    localparam int T_W  = P_W - K;

    // Multiples of Q at full remainder width (compares) and residue width (subtraction)
    localparam logic [DIN_W:0]  Q1_X = (DIN_W + 1)'(Q);
    localparam logic [DIN_W:0]  Q2_X = (DIN_W + 1)'(2 * Q);
    localparam logic [DIN_W:0]  Q3_X = (DIN_W + 1)'(3 * Q);
    localparam logic [QW-1:0]   Q1_L = QW'(Q);
    localparam logic [QW-1:0]   Q2_L = QW'(2 * Q);
    localparam logic [QW-1:0]   Q3_L = QW'(3 * Q);

    // Stage registers
    logic             r_s1_valid;
    logic [P_W-1:0]   r_s1_p;
    logic [DIN_W-1:0] r_s1_din;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [DIN_W:0]   r_s2_r;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_s3_valid;
    logic [QW-1:0]    r_s3_dout;
    logic [TAG_W-1:0] r_s3_tag;

    // Combinational datapath
    logic             w_advance;
    logic [QQ_W-1:0]  w_q;
    logic [P_W-1:0]   w_p;
    logic [T_W-1:0]   w_t;
    logic [DIN_W:0]   w_tq;
    logic [DIN_W:0]   w_r;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_ge3;
    logic [QW-1:0]    w_sub;
    logic [QW-1:0]    w_red;
    logic             w_unused_p_lo;

    // Whole pipeline moves as one: only a held, unaccepted output word stalls it
    assign w_advance = out_ready | ~r_s3_valid;
    assign in_ready  = rst_n & w_advance;

    assign w_q = din[DIN_W-1:K];
    assign w_p = P_W'(w_q) * P_W'(MU);

    // The low K bits of p are discarded by the shift
    assign w_t           = r_s1_p[P_W-1:K];
    assign w_unused_p_lo = ^r_s1_p[K-1:0];
    assign w_tq          = (DIN_W + 1)'(w_t) * Q1_X;
    assign w_r           = {1'b0, r_s1_din} - w_tq;

    // The final residue is below Q < 2^QW, so the subtraction only needs the low QW bits
    assign w_ge1 = (r_s2_r >= Q1_X);
    assign w_ge2 = (r_s2_r >= Q2_X);
    assign w_ge3 = (r_s2_r >= Q3_X);
    assign w_sub = w_ge3 ? Q3_L : (w_ge2 ? Q2_L : (w_ge1 ? Q1_L : '0));
    assign w_red = r_s2_r[QW-1:0] - w_sub;

    assign out_valid = r_s3_valid;
    assign dout      = r_s3_dout;
    assign out_tag   = r_s3_tag;

    // Stage 1: quotient estimate product, carry din and tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_din   <= '0;
            r_s1_tag   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_p   <= w_p;
                r_s1_din <= din;
                r_s1_tag <= in_tag;
            end
        end
    end

    // Stage 2: partial remainder din - t*Q, known to lie in [0, 4Q)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_tag   <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_r   <= w_r;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    // Stage 3: final correction; data only updates on a valid word so dout stays 0 until the first result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_dout  <= '0;
            r_s3_tag   <= '0;
        end else if (w_advance) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_dout <= w_red;
                r_s3_tag  <= r_s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb/tb_barrett_reduce_pipe.sv - self-checking bench for barrett_reduce_pipe (Q=277)
module tb_barrett_reduce_pipe;

    localparam int Q     = 277;
    localparam int QW    = 9;
    localparam int DIN_W = 18;
    localparam int TAG_W = 4;
    localparam int N_DIR = 19;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DIN_W-1:0] din;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [QW-1:0]    dout;
    logic [TAG_W-1:0] out_tag;

    int n_vec        = 0;
    int n_miscompares = 0;
    int exp_q[$];
    int tag_q[$];
    int cur_exp      = 0;
    int rdy_mode     = 0;

    // hand-computed residues mod 277
    int vd [N_DIR] = '{0, 1, 276, 277, 278, 553, 554, 830, 831, 1107, 1108,
                       1000, 12345, 65535, 76728, 100000, 131071, 200000, 262143};
    int ve [N_DIR] = '{0, 1, 276, 0, 1, 276, 0, 276, 0, 276, 0,
                       169, 157, 163, 276, 3, 50, 6, 101};

    barrett_reduce_pipe #(
        .Q     (Q),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // consumer: always ready, never ready, or random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // scoreboard: checks outputs in order, holds under stall, records accepted inputs
    logic [QW-1:0]    prev_dout;
    logic [TAG_W-1:0] prev_tag;
    bit               prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_dout", 32'(dout), int'(prev_dout));
                check("hold_tag", 32'(out_tag), int'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 0);
                end else begin
                    check("dout", 32'(dout), exp_q.pop_front());
                    check("tag", 32'(out_tag), tag_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                tag_q.push_back(int'(in_tag));
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_tag   = out_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input int d, input int e, input bit allow_gap);
        int  waited;
        bit  ok;
        waited = 0;
        if (allow_gap) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        din      = DIN_W'(d);
        cur_exp  = e;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'(waited), 0);
                break;
            end
        end
        in_tag   = in_tag + 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // latency: valid appears in the third cycle after the accept cycle
        send(276, 276, 1'b0);
        @(negedge clk);
        check("lat_c1_valid", 32'(out_valid), 0);
        check("lat_c1_dout", 32'(dout), 0);
        @(negedge clk);
        check("lat_c2_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_c3_valid", 32'(out_valid), 1);
        drain();

        // directed boundaries, back to back at full throughput
        for (int i = 0; i < N_DIR; i++) send(vd[i], ve[i], 1'b0);
        drain();

        // stride sweep across the whole input range
        for (int d = 0; d < (1 << DIN_W); d += 131) send(d, d % Q, 1'b0);
        drain();

        // random backpressure and input bubbles
        rdy_mode = 2;
        for (int i = 0; i < N_DIR; i++) send(vd[i], ve[i], 1'b1);
        for (int d = 7; d < (1 << DIN_W); d += 1021) send(d, d % Q, 1'b1);
        drain();

        // reset with three words held in the pipeline
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(1000, 169, 1'b0);
        send(12345, 157, 1'b0);
        send(65535, 163, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        check("rst_mid_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_dout", 32'(dout), 0);
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < N_DIR; i++) send(vd[i], ve[i], 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompares);
        $finish;
    end

endmodule
